// File: rtl/fpu_wb_demux_2_threading.sv
// Writeback demux for the two-thread FPU: tracks the issuing thread of each op through
// the fixed-latency pipe, steers results to per-thread FP register files, counts in-flight writes.
module fpu_wb_demux_2_threading #(
  parameter int LAT = 4,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          e,
  input  logic          s,
  input  logic          wf,
  input  logic [4:0]    fd,
  input  logic          stall,
  input  logic          flush0,
  input  logic          flush1,
  input  logic [31:0]   wd,
  output logic          wf0,
  output logic [4:0]    fd0,
  output logic [31:0]   wd0,
  output logic          wf1,
  output logic [4:0]    fd1,
  output logic [31:0]   wd1,
  output logic [CW-1:0] pend0,
  output logic [CW-1:0] pend1,
  output logic          busy0,
  output logic          busy1
);

  logic [LAT-1:0]      v_q, v_d;
  logic [LAT-1:0]      t_q, t_d;
  logic [LAT-1:0]      w_q, w_d;
  logic [LAT-1:0][4:0] d_q, d_d;
  logic [CW-1:0]       pend0_q, pend0_d;
  logic [CW-1:0]       pend1_q, pend1_d;
  logic                acc_s;
  logic                retire_s;
  logic                inc0_s;
  logic                inc1_s;

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur, input logic clr,
                                             input logic inc, input logic dec);
    logic [CW-1:0] r;
    if (clr) begin
      r = {CW{1'b0}};
    end else if (inc && !dec) begin
      r = cur + CW'(1);
    end else if (dec && !inc) begin
      r = cur - CW'(1);
    end else begin
      r = cur;
    end
    return r;
  endfunction

  assign acc_s    = e && !stall;
  assign retire_s = v_q[LAT-1] && w_q[LAT-1] && !stall;
  assign wf0      = retire_s && !t_q[LAT-1] && !flush0;
  assign wf1      = retire_s &&  t_q[LAT-1] && !flush1;
  assign fd0      = d_q[LAT-1];
  assign fd1      = d_q[LAT-1];
  assign wd0      = wd;
  assign wd1      = wd;
  assign inc0_s   = acc_s && !s && wf;
  assign inc1_s   = acc_s &&  s && wf;
  assign pend0    = pend0_q;
  assign pend1    = pend1_q;
  assign busy0    = (pend0_q != {CW{1'b0}});
  assign busy1    = (pend1_q != {CW{1'b0}});

  // Tag shift/hold, then flush kill applied to whatever lands in each entry
  // (this also drops a same-cycle issue from the flushed thread).
  always_comb begin
    v_d = v_q;
    t_d = t_q;
    w_d = w_q;
    d_d = d_q;
    if (!stall) begin
      v_d[0] = acc_s;
      t_d[0] = s;
      w_d[0] = wf;
      d_d[0] = fd;
      for (int i = 1; i < LAT; i++) begin
        v_d[i] = v_q[i-1];
        t_d[i] = t_q[i-1];
        w_d[i] = w_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end else begin
      v_d = v_q;
    end
    for (int i = 0; i < LAT; i++) begin
      v_d[i] = v_d[i] && !((flush0 && !t_d[i]) || (flush1 && t_d[i]));
    end
  end

  // Per-thread in-flight write counters.
  always_comb begin
    pend0_d = cnt_next(pend0_q, flush0, inc0_s, wf0);
    pend1_d = cnt_next(pend1_q, flush1, inc1_s, wf1);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= {LAT{1'b0}};
      t_q     <= {LAT{1'b0}};
      w_q     <= {LAT{1'b0}};
      d_q     <= {(LAT*5){1'b0}};
      pend0_q <= {CW{1'b0}};
      pend1_q <= {CW{1'b0}};
    end else begin
      v_q     <= v_d;
      t_q     <= t_d;
      w_q     <= w_d;
      d_q     <= d_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
    end
  end

endmodule

// File: tb/tb_fpu_wb_demux_2_threading.sv
// Directed bench for fpu_wb_demux_2_threading (LAT=4): each step drives one cycle of
// inputs and checks the hand-computed enables, addresses, data and counters.
module tb_fpu_wb_demux_2_threading;
  localparam int   LAT = 4;
  localparam int   CW  = 4;
  localparam logic O   = 1'b1;
  localparam logic Z   = 1'b0;

  logic          clk, rst, e, s, wf, stall, flush0, flush1;
  logic [4:0]    fd, fd0, fd1;
  logic [31:0]   wd, wd0, wd1;
  logic          wf0, wf1, busy0, busy1;
  logic [CW-1:0] pend0, pend1;
  int            nvec, nerr;

  fpu_wb_demux_2_threading #(.LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .e(e), .s(s), .wf(wf), .fd(fd), .stall(stall),
    .flush0(flush0), .flush1(flush1), .wd(wd),
    .wf0(wf0), .fd0(fd0), .wd0(wd0), .wf1(wf1), .fd1(fd1), .wd1(wd1),
    .pend0(pend0), .pend1(pend1), .busy0(busy0), .busy1(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, check combinational/registered outputs, advance past the edge.
  task automatic cyc(input string tag,
                     input logic i_e, input logic i_s, input logic i_wf, input logic [4:0] i_fd,
                     input logic i_st, input logic i_f0, input logic i_f1,
                     input logic x_w0, input logic [4:0] x_d0,
                     input logic x_w1, input logic [4:0] x_d1,
                     input logic [3:0] x_p0, input logic [3:0] x_p1);
    e = i_e; s = i_s; wf = i_wf; fd = i_fd; stall = i_st; flush0 = i_f0; flush1 = i_f1;
    wd = $urandom;
    #1;
    chk({tag, ".wf0"}, {31'd0, wf0}, {31'd0, x_w0});
    chk({tag, ".wf1"}, {31'd0, wf1}, {31'd0, x_w1});
    chk({tag, ".pend0"}, {28'd0, pend0}, {28'd0, x_p0});
    chk({tag, ".pend1"}, {28'd0, pend1}, {28'd0, x_p1});
    chk({tag, ".busy0"}, {31'd0, busy0}, {31'd0, (x_p0 != 4'd0)});
    chk({tag, ".busy1"}, {31'd0, busy1}, {31'd0, (x_p1 != 4'd0)});
    chk({tag, ".bound"}, {31'd0, (pend0 <= 4'd4) && (pend1 <= 4'd4)}, 32'd1);
    if (x_w0) begin
      chk({tag, ".fd0"}, {27'd0, fd0}, {27'd0, x_d0});
      chk({tag, ".wd0"}, wd0, wd);
    end
    if (x_w1) begin
      chk({tag, ".fd1"}, {27'd0, fd1}, {27'd0, x_d1});
      chk({tag, ".wd1"}, wd1, wd);
    end
    tick();
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1; e = 1'b0; s = 1'b0; wf = 1'b0; fd = 5'd0; stall = 1'b0;
    flush0 = 1'b0; flush1 = 1'b0; wd = 32'd0;
    cyc("rst_a", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("rst_b", O,Z,O,5'd3, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    rst = 1'b0;

    // 1: basic steering
    cyc("t1_c1", O,Z,O,5'd5, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t1_c2", O,O,O,5'd9, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t1_c3", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd1);
    cyc("t1_c4", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd1);
    cyc("t1_c5", Z,Z,Z,5'd0, Z,Z,Z,  O,5'd5, Z,5'd0, 4'd1,4'd1);
    cyc("t1_c6", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, O,5'd9, 4'd0,4'd1);
    cyc("t1_c7", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);

    // 2: back-to-back thread 1
    cyc("t2_c1", O,O,O,5'd1, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t2_c2", O,O,O,5'd2, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd1);
    cyc("t2_c3", O,O,O,5'd3, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd2);
    cyc("t2_c4", O,O,O,5'd4, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd3);
    cyc("t2_c5", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, O,5'd1, 4'd0,4'd4);
    cyc("t2_c6", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, O,5'd2, 4'd0,4'd3);
    cyc("t2_c7", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, O,5'd3, 4'd0,4'd2);
    cyc("t2_c8", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, O,5'd4, 4'd0,4'd1);
    cyc("t2_c9", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);

    // 3: stall with the op sitting in the last entry; an issue under stall is refused
    cyc("t3_c1", O,Z,O,5'd7, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t3_c2", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c3", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c4", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c5", Z,Z,Z,5'd0, O,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c6", O,O,O,5'd8, O,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c7", Z,Z,Z,5'd0, O,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c8", Z,Z,Z,5'd0, Z,Z,Z,  O,5'd7, Z,5'd0, 4'd1,4'd0);
    cyc("t3_c9", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t3_ca", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);

    // 4: selective flush of thread 0 (first t0 op is in the last entry when flushed)
    cyc("t4_c1", O,Z,O,5'd10, Z,Z,Z, Z,5'd0, Z,5'd0,  4'd0,4'd0);
    cyc("t4_c2", O,O,O,5'd11, Z,Z,Z, Z,5'd0, Z,5'd0,  4'd1,4'd0);
    cyc("t4_c3", O,Z,O,5'd12, Z,Z,Z, Z,5'd0, Z,5'd0,  4'd1,4'd1);
    cyc("t4_c4", O,O,O,5'd13, Z,Z,Z, Z,5'd0, Z,5'd0,  4'd2,4'd1);
    cyc("t4_c5", Z,Z,Z,5'd0,  Z,O,Z, Z,5'd0, Z,5'd0,  4'd2,4'd2);
    cyc("t4_c6", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, O,5'd11, 4'd0,4'd2);
    cyc("t4_c7", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0,  4'd0,4'd1);
    cyc("t4_c8", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, O,5'd13, 4'd0,4'd1);
    cyc("t4_c9", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0,  4'd0,4'd0);

    // 5: flush1 with same-cycle issues from thread 1 (dropped) and thread 0 (kept)
    cyc("t5_c1", O,O,O,5'd20, Z,Z,O, Z,5'd0,  Z,5'd0, 4'd0,4'd0);
    cyc("t5_c2", O,Z,O,5'd21, Z,Z,O, Z,5'd0,  Z,5'd0, 4'd0,4'd0);
    cyc("t5_c3", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0,  Z,5'd0, 4'd1,4'd0);
    cyc("t5_c4", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0,  Z,5'd0, 4'd1,4'd0);
    cyc("t5_c5", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0,  Z,5'd0, 4'd1,4'd0);
    cyc("t5_c6", Z,Z,Z,5'd0,  Z,Z,Z, O,5'd21, Z,5'd0, 4'd1,4'd0);
    cyc("t5_c7", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0,  Z,5'd0, 4'd0,4'd0);

    // 6: asynchronous reset between edges with three ops in flight
    cyc("t6_c1", O,Z,O,5'd1, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t6_c2", O,O,O,5'd2, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd0);
    cyc("t6_c3", O,Z,O,5'd3, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd1,4'd1);
    chk("t6_pre.pend0", {28'd0, pend0}, 32'd2);
    rst = 1'b1;
    cyc("t6_rst", Z,Z,Z,5'd0, Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    rst = 1'b0;
    cyc("t6_p1", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t6_p2", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t6_p3", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t6_p4", Z,Z,Z,5'd0, Z,Z,Z,  Z,5'd0, Z,5'd0, 4'd0,4'd0);

    // 7: no-write ops retire silently
    cyc("t7_c1", O,Z,Z,5'd30, Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t7_c2", O,O,Z,5'd31, Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t7_c3", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t7_c4", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t7_c5", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t7_c6", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);
    cyc("t7_c7", Z,Z,Z,5'd0,  Z,Z,Z, Z,5'd0, Z,5'd0, 4'd0,4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
